// File: rtl/i2c_pkg.sv
// Shared I2C definitions: byte width, ACK/NACK line levels and the
// responder FSM state encoding.
package i2c_pkg;

    localparam int BYTE_W = 8;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        SUB,
        SUB_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } i2cState_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with SCL edge detection and START/STOP detection.
// Both lines idle high, so every synchronizer stage resets to 1.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sdaLevel_o,
    output logic sclRise_o,
    output logic sclFall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclPrev_q;
    logic                   sdaPrev_q;
    logic                   sclLevel;
    logic                   sdaLevel;

    // Shift both lines through the synchronizer chains and keep the previous
    // synchronized levels for edge detection.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_i};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_i};
            sclPrev_q <= sclLevel;
            sdaPrev_q <= sdaLevel;
        end
    end

    assign sclLevel = sclSync_q[SYNC_STAGES-1];
    assign sdaLevel = sdaSync_q[SYNC_STAGES-1];

    // SDA edges only count as START/STOP when SCL was high on both samples,
    // so an SDA change racing an SCL edge is never misread as a condition.
    assign sdaLevel_o = sdaLevel;
    assign sclRise_o  = sclLevel & ~sclPrev_q;
    assign sclFall_o  = ~sclLevel & sclPrev_q;
    assign start_o    = sclLevel & sclPrev_q & sdaPrev_q & ~sdaLevel;
    assign stop_o     = sclLevel & sclPrev_q & ~sdaPrev_q & sdaLevel;

endmodule

// File: rtl/i2c_responder.sv
// I2C target exposing an 8-bit register space behind a sub-address pointer.
// Optional burst access: define I2C_AUTO_INC_EN to auto-increment the
// pointer after every register write and every register read.
module i2c_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h4C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              SCL,
    inout  wire               SDA,
    output logic [BYTE_W-1:0] reg_addr,
    output logic [BYTE_W-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [BYTE_W-1:0] reg_rdata,
    output logic              busy,
    output logic              addr_hit
);

    logic sdaLevel;
    logic sclRise;
    logic sclFall;
    logic startDet;
    logic stopDet;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lineSync (
        .clock_i   (clk_50),
        .reset_i   (reset),
        .scl_i     (SCL),
        .sda_i     (SDA),
        .sdaLevel_o(sdaLevel),
        .sclRise_o (sclRise),
        .sclFall_o (sclFall),
        .start_o   (startDet),
        .stop_o    (stopDet)
    );

    i2cState_t         state_q, state_d;
    logic [3:0]        bitCnt_q, bitCnt_d;
    logic [6:0]        shift_q, shift_d;
    logic [BYTE_W-1:0] pointer_q, pointer_d;
    logic [BYTE_W-1:0] txByte_q, txByte_d;
    logic [BYTE_W-1:0] regAddr_q, regAddr_d;
    logic [BYTE_W-1:0] regWdata_q, regWdata_d;
    logic              sdaLow_q, sdaLow_d;
    logic              busy_q, busy_d;
    logic              addrHit_q, addrHit_d;
    logic              regWr_q, regWr_d;
    logic              regRd_q, regRd_d;
    logic              isRead_q, isRead_d;
    logic [BYTE_W-1:0] rxByte;
    logic [BYTE_W-1:0] nextPtr;

    assign rxByte = {shift_q, sdaLevel};

`ifdef I2C_AUTO_INC_EN
    assign nextPtr = pointer_q + 8'd1;
`else
    assign nextPtr = pointer_q;
`endif

    // State and output registers; reset releases SDA immediately.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            pointer_q  <= '0;
            txByte_q   <= '0;
            regAddr_q  <= '0;
            regWdata_q <= '0;
            sdaLow_q   <= 1'b0;
            busy_q     <= 1'b0;
            addrHit_q  <= 1'b0;
            regWr_q    <= 1'b0;
            regRd_q    <= 1'b0;
            isRead_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            pointer_q  <= pointer_d;
            txByte_q   <= txByte_d;
            regAddr_q  <= regAddr_d;
            regWdata_q <= regWdata_d;
            sdaLow_q   <= sdaLow_d;
            busy_q     <= busy_d;
            addrHit_q  <= addrHit_d;
            regWr_q    <= regWr_d;
            regRd_q    <= regRd_d;
            isRead_q   <= isRead_d;
        end
    end

    // Bus protocol: bits are sampled on SCL rise, SDA only moves on SCL fall.
    // ACK states use sdaLow_q as their phase: the first fall starts the ACK,
    // the second fall ends it and hands over to the next byte.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        pointer_d  = pointer_q;
        txByte_d   = txByte_q;
        regAddr_d  = regAddr_q;
        regWdata_d = regWdata_q;
        sdaLow_d   = sdaLow_q;
        busy_d     = busy_q;
        addrHit_d  = 1'b0;
        regWr_d    = 1'b0;
        regRd_d    = 1'b0;
        isRead_d   = isRead_q;

        if (regRd_q) begin
            txByte_d = reg_rdata;
        end

        if (stopDet) begin
            state_d  = IDLE;
            bitCnt_d = '0;
            sdaLow_d = 1'b0;
            busy_d   = 1'b0;
        end else if (startDet) begin
            state_d  = ADDR;
            bitCnt_d = '0;
            sdaLow_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (sclRise) begin
                        shift_d  = rxByte[6:0];
                        bitCnt_d = bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd7) begin
                            if (rxByte[7:1] == DEV_ADDR) begin
                                state_d   = ADDR_ACK;
                                addrHit_d = 1'b1;
                                busy_d    = 1'b1;
                                isRead_d  = rxByte[0];
                                if (rxByte[0]) begin
                                    regRd_d   = 1'b1;
                                    regAddr_d = pointer_q;
                                    pointer_d = nextPtr;
                                end
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (sclFall) begin
                        if (!sdaLow_q) begin
                            sdaLow_d = 1'b1;
                        end else begin
                            bitCnt_d = '0;
                            if (isRead_q) begin
                                state_d  = RDATA;
                                sdaLow_d = ~txByte_q[7];
                            end else begin
                                state_d  = SUB;
                                sdaLow_d = 1'b0;
                            end
                        end
                    end
                end
                SUB: begin
                    if (sclRise) begin
                        shift_d  = rxByte[6:0];
                        bitCnt_d = bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd7) begin
                            pointer_d = rxByte;
                            state_d   = SUB_ACK;
                        end
                    end
                end
                SUB_ACK: begin
                    if (sclFall) begin
                        if (!sdaLow_q) begin
                            sdaLow_d = 1'b1;
                        end else begin
                            sdaLow_d = 1'b0;
                            bitCnt_d = '0;
                            state_d  = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (sclRise) begin
                        shift_d  = rxByte[6:0];
                        bitCnt_d = bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd7) begin
                            regWdata_d = rxByte;
                            regAddr_d  = pointer_q;
                            regWr_d    = 1'b1;
                            pointer_d  = nextPtr;
                            state_d    = WDATA_ACK;
                        end
                    end
                end
                WDATA_ACK: begin
                    if (sclFall) begin
                        if (!sdaLow_q) begin
                            sdaLow_d = 1'b1;
                        end else begin
                            sdaLow_d = 1'b0;
                            bitCnt_d = '0;
                            state_d  = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (sclRise && bitCnt_q != 4'd8) begin
                        bitCnt_d = bitCnt_q + 4'd1;
                    end
                    if (sclFall) begin
                        if (bitCnt_q == 4'd8) begin
                            sdaLow_d = 1'b0;
                            state_d  = RDATA_ACK;
                        end else begin
                            sdaLow_d = ~txByte_q[~bitCnt_q[2:0]];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (sclRise) begin
                        if (sdaLevel == I2C_ACK) begin
                            regRd_d   = 1'b1;
                            regAddr_d = pointer_q;
                            pointer_d = nextPtr;
                            bitCnt_d  = '0;
                            state_d   = RDATA;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign SDA       = sdaLow_q ? 1'b0 : 1'bz;
    assign reg_addr  = regAddr_q;
    assign reg_wdata = regWdata_q;
    assign reg_wr    = regWr_q;
    assign reg_rd    = regRd_q;
    assign busy      = busy_q;
    assign addr_hit  = addrHit_q;

endmodule

// File: tb/tb_i2c_responder.sv
// Testbench for i2c_responder: a bit-banged I2C master plus a register-file
// owner, checked against a memory model of what the bus transactions mean.
// Expectations follow I2C_AUTO_INC_EN the same way the design does.
module tb_i2c_responder;
    import i2c_pkg::*;

    localparam int Q = 6;
`ifdef I2C_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    logic       clk_50 = 1'b0;
    logic       reset;
    logic       SCL;
    logic       masterSdaLow;
    wire        sdaBus;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       reg_wr;
    logic       reg_rd;
    logic       busy;
    logic       addr_hit;

    logic [7:0] regMem   [256];
    logic [7:0] modelMem [256];
    logic [7:0] wrAddrQ [$];
    logic [7:0] wrDataQ [$];
    logic [7:0] rdAddrQ [$];
    int         hitCount;
    int         driveCycles;
    int         holdViolations;
    logic       prevScl;
    logic       prevDrive;
    logic       dutDrive;
    int         checks;
    int         errors;

    assign sdaBus = masterSdaLow ? 1'b0 : 1'bz;
    pullup (sdaBus);
    assign reg_rdata = regMem[reg_addr];

    always #10 clk_50 = ~clk_50;

    i2c_responder #(
        .DEV_ADDR   (7'h4C),
        .SYNC_STAGES(2)
    ) u_dut (
        .clk_50   (clk_50),
        .reset    (reset),
        .SCL      (SCL),
        .SDA      (sdaBus),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_wr   (reg_wr),
        .reg_rd   (reg_rd),
        .reg_rdata(reg_rdata),
        .busy     (busy),
        .addr_hit (addr_hit)
    );

    // Register owner and bus observer: records strobes, stores writes, and
    // flags any change of the responder's SDA drive while SCL stays high.
    always @(negedge clk_50) begin
        if (reg_wr) begin
            wrAddrQ.push_back(reg_addr);
            wrDataQ.push_back(reg_wdata);
            regMem[reg_addr] = reg_wdata;
        end
        if (reg_rd) rdAddrQ.push_back(reg_addr);
        if (addr_hit) hitCount++;
        dutDrive = (sdaBus === 1'b0) && !masterSdaLow;
        if (dutDrive) driveCycles++;
        if (!reset && SCL && prevScl && (dutDrive != prevDrive)) holdViolations++;
        prevScl   = SCL;
        prevDrive = dutDrive;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic clearMon();
        wrAddrQ.delete();
        wrDataQ.delete();
        rdAddrQ.delete();
        hitCount    = 0;
        driveCycles = 0;
    endtask

    task automatic i2cStart();
        masterSdaLow = 1'b0;
        waitClk(2 * Q);
        SCL = 1'b1;
        waitClk(2 * Q);
        masterSdaLow = 1'b1;
        waitClk(2 * Q);
        SCL = 1'b0;
    endtask

    task automatic i2cStop();
        masterSdaLow = 1'b1;
        waitClk(Q);
        SCL = 1'b1;
        waitClk(2 * Q);
        masterSdaLow = 1'b0;
        waitClk(2 * Q);
    endtask

    task automatic writeBit(input logic b);
        waitClk(Q);
        masterSdaLow = ~b;
        waitClk(Q);
        SCL = 1'b1;
        waitClk(2 * Q);
        SCL = 1'b0;
    endtask

    task automatic readBit(output logic b);
        masterSdaLow = 1'b0;
        waitClk(2 * Q);
        SCL = 1'b1;
        waitClk(Q);
        b = sdaBus;
        waitClk(Q);
        SCL = 1'b0;
    endtask

    task automatic sendBits(input logic [7:0] data);
        for (int i = 7; i >= 0; i--) writeBit(data[i]);
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] data, input logic expAck);
        logic ack;
        sendBits(data);
        readBit(ack);
        checkOutput(tag, 32'(ack), 32'(expAck));
    endtask

    task automatic readByte(input logic ackBit, output logic [7:0] data);
        logic b;
        data = '0;
        for (int i = 0; i < 8; i++) begin
            readBit(b);
            data = {data[6:0], b};
        end
        writeBit(ackBit);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] sub;
        logic [7:0] ptr;
        logic [7:0] expAddr;
        logic [7:0] txData [4];
        int         n;

        checks = 0;
        errors = 0;
        holdViolations = 0;
        prevScl = 1'b1;
        prevDrive = 1'b0;
        reset = 1'b1;
        SCL = 1'b1;
        masterSdaLow = 1'b0;
        for (int i = 0; i < 256; i++) begin
            regMem[i]   = 8'($urandom);
            modelMem[i] = regMem[i];
        end
        clearMon();
        waitClk(5);
        checkOutput("rstSda", 32'(sdaBus), 32'd1);
        checkOutput("rstRegAddr", 32'(reg_addr), 32'd0);
        checkOutput("rstRegWdata", 32'(reg_wdata), 32'd0);
        checkOutput("rstRegWr", 32'(reg_wr), 32'd0);
        checkOutput("rstRegRd", 32'(reg_rd), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstAddrHit", 32'(addr_hit), 32'd0);
        reset = 1'b0;
        waitClk(2 * Q);

        $display("[TB] single write 0x1B <= 0xA5");
        clearMon();
        i2cStart();
        applyStimulus("w1AddrAck", 8'h98, I2C_ACK);
        checkOutput("w1BusyAfterAddr", 32'(busy), 32'd1);
        applyStimulus("w1SubAck", 8'h1B, I2C_ACK);
        applyStimulus("w1DataAck", 8'hA5, I2C_ACK);
        checkOutput("w1BusyBeforeStop", 32'(busy), 32'd1);
        i2cStop();
        checkOutput("w1BusyAfterStop", 32'(busy), 32'd0);
        checkOutput("w1WrCount", 32'(wrAddrQ.size()), 32'd1);
        if (wrAddrQ.size() == 1) begin
            checkOutput("w1WrAddr", 32'(wrAddrQ[0]), 32'h1B);
            checkOutput("w1WrData", 32'(wrDataQ[0]), 32'hA5);
        end
        checkOutput("w1Hits", 32'(hitCount), 32'd1);
        modelMem[8'h1B] = 8'hA5;

        $display("[TB] foreign address 0x4D");
        clearMon();
        i2cStart();
        applyStimulus("nackAddr", 8'h9A, I2C_NACK);
        applyStimulus("nackData", 8'h55, I2C_NACK);
        checkOutput("nackState", 32'(u_dut.state_q), 32'(IGNORE));
        checkOutput("nackDrive", 32'(driveCycles), 32'd0);
        checkOutput("nackHits", 32'(hitCount), 32'd0);
        checkOutput("nackBusy", 32'(busy), 32'd0);
        i2cStop();
        checkOutput("nackWrCount", 32'(wrAddrQ.size()), 32'd0);

        $display("[TB] address-only write");
        clearMon();
        i2cStart();
        applyStimulus("aoAddrAck", 8'h98, I2C_ACK);
        i2cStop();
        checkOutput("aoWrCount", 32'(wrAddrQ.size()), 32'd0);
        checkOutput("aoHits", 32'(hitCount), 32'd1);

        $display("[TB] repeated-start read of 0x10");
        regMem[8'h10]   = 8'h3C;
        modelMem[8'h10] = 8'h3C;
        clearMon();
        i2cStart();
        applyStimulus("rdAddrW", 8'h98, I2C_ACK);
        applyStimulus("rdSub", 8'h10, I2C_ACK);
        i2cStart();
        applyStimulus("rdAddrR", 8'h99, I2C_ACK);
        readByte(I2C_NACK, got);
        checkOutput("rdData", 32'(got), 32'h3C);
        checkOutput("rdCount", 32'(rdAddrQ.size()), 32'd1);
        if (rdAddrQ.size() == 1) checkOutput("rdRegAddr", 32'(rdAddrQ[0]), 32'h10);
        waitClk(Q);
        checkOutput("rdReleased", 32'(sdaBus), 32'd1);
        checkOutput("rdState", 32'(u_dut.state_q), 32'(IGNORE));
        checkOutput("rdHits", 32'(hitCount), 32'd2);
        i2cStop();
        checkOutput("rdWrCount", 32'(wrAddrQ.size()), 32'd0);

        $display("[TB] burst write from 0xFE");
        clearMon();
        txData[0] = 8'h11;
        txData[1] = 8'h22;
        txData[2] = 8'h33;
        i2cStart();
        applyStimulus("bwAddr", 8'h98, I2C_ACK);
        applyStimulus("bwSub", 8'hFE, I2C_ACK);
        for (int i = 0; i < 3; i++) applyStimulus("bwData", txData[i], I2C_ACK);
        i2cStop();
        checkOutput("bwWrCount", 32'(wrAddrQ.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            expAddr = AUTO_INC ? 8'(8'hFE + i) : 8'hFE;
            modelMem[expAddr] = txData[i];
            if (i < wrAddrQ.size()) begin
                checkOutput("bwWrAddr", 32'(wrAddrQ[i]), 32'(expAddr));
                checkOutput("bwWrData", 32'(wrDataQ[i]), 32'(txData[i]));
            end
        end

        $display("[TB] stop in the middle of a data byte");
        clearMon();
        i2cStart();
        applyStimulus("msAddr", 8'h98, I2C_ACK);
        applyStimulus("msSub", 8'h20, I2C_ACK);
        for (int i = 0; i < 4; i++) writeBit(1'b1);
        i2cStop();
        waitClk(Q);
        checkOutput("msWrCount", 32'(wrAddrQ.size()), 32'd0);
        checkOutput("msBusy", 32'(busy), 32'd0);
        checkOutput("msState", 32'(u_dut.state_q), 32'(IDLE));

        $display("[TB] reset during sub-address ACK");
        clearMon();
        i2cStart();
        applyStimulus("raAddr", 8'h98, I2C_ACK);
        sendBits(8'h33);
        masterSdaLow = 1'b0;
        waitClk(Q);
        checkOutput("raAckHeld", 32'(sdaBus), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("raSdaZ", 32'(sdaBus), 32'd1);
        checkOutput("raBusy", 32'(busy), 32'd0);
        checkOutput("raRegAddr", 32'(reg_addr), 32'd0);
        checkOutput("raRegWdata", 32'(reg_wdata), 32'd0);
        checkOutput("raState", 32'(u_dut.state_q), 32'(IDLE));
        waitClk(3);
        reset = 1'b0;
        SCL = 1'b1;
        waitClk(2 * Q);
        clearMon();
        i2cStart();
        applyStimulus("raNextAddr", 8'h98, I2C_ACK);
        applyStimulus("raNextSub", 8'h44, I2C_ACK);
        applyStimulus("raNextData", 8'h5A, I2C_ACK);
        i2cStop();
        modelMem[8'h44] = 8'h5A;
        checkOutput("raNextWrCount", 32'(wrAddrQ.size()), 32'd1);
        if (wrAddrQ.size() == 1) begin
            checkOutput("raNextWrAddr", 32'(wrAddrQ[0]), 32'h44);
            checkOutput("raNextWrData", 32'(wrDataQ[0]), 32'h5A);
        end

        $display("[TB] randomized write/read transactions");
        for (int it = 0; it < 6; it++) begin
            clearMon();
            sub = 8'($urandom);
            n   = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) txData[i] = 8'($urandom);
            i2cStart();
            applyStimulus("rnAddrW", 8'h98, I2C_ACK);
            applyStimulus("rnSub", sub, I2C_ACK);
            for (int i = 0; i < n; i++) applyStimulus("rnDataAck", txData[i], I2C_ACK);
            i2cStop();
            checkOutput("rnWrCount", 32'(wrAddrQ.size()), 32'(n));
            for (int i = 0; i < n; i++) begin
                expAddr = AUTO_INC ? 8'(sub + 8'(i)) : sub;
                modelMem[expAddr] = txData[i];
                if (i < wrAddrQ.size()) begin
                    checkOutput("rnWrAddr", 32'(wrAddrQ[i]), 32'(expAddr));
                    checkOutput("rnWrData", 32'(wrDataQ[i]), 32'(txData[i]));
                end
            end

            clearMon();
            ptr = (it % 2 == 0) ? sub : 8'($urandom);
            n   = int'($urandom_range(1, 3));
            i2cStart();
            applyStimulus("rnRdAddrW", 8'h98, I2C_ACK);
            applyStimulus("rnRdSub", ptr, I2C_ACK);
            i2cStart();
            applyStimulus("rnRdAddrR", 8'h99, I2C_ACK);
            for (int j = 0; j < n; j++) begin
                readByte((j == n - 1) ? I2C_NACK : I2C_ACK, got);
                checkOutput("rnRdData", 32'(got), 32'(modelMem[ptr]));
                if (AUTO_INC) ptr = ptr + 8'd1;
            end
            i2cStop();
            checkOutput("rnRdCount", 32'(rdAddrQ.size()), 32'(n));
            checkOutput("rnBusy", 32'(busy), 32'd0);
        end

        checkOutput("holdViolations", 32'(holdViolations), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_responder.md
Name: i2c_responder

Overview:
- I2C target (responder) for the on-board bus; the other end of the existing I2C master used to configure the HDMI receiver.
- Lets the FPGA appear as a register-mapped device at a 7-bit address, with an 8-bit sub-address pointer, matching the ADV7611 access model.
- Bridges bus transactions onto a simple synchronous register port, so the design can expose status and config registers to an external host or test master.

Parameters:
- DEV_ADDR, 7'h4C, 7-bit I2C device address this block answers to.
- SYNC_STAGES, 2, flip-flop stages on SCL/SDA before edge detection (minimum 2).

Ports:
- clk_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- SCL  in  1  I2C clock line; input only, no clock stretching.
- SDA  inout  1  I2C data line; driven 1'b0 or 1'bZ only.
- reg_addr  out  8  sub-address for the current register access.
- reg_wdata  out  8  write data, valid while reg_wr is high.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe; reg_rdata is sampled on the following clk_50 cycle.
- reg_rdata  in  8  read data from the register owner.
- busy  out  1  high from a START with address match until STOP.
- addr_hit  out  1  one-cycle pulse on each ACKed address byte.

Behaviour:
- Reset values: SDA = Z, reg_addr = 0, reg_wdata = 0, reg_wr = 0, reg_rd = 0, busy = 0, addr_hit = 0, FSM = IDLE, pointer = 0.
- Input conditioning: SCL and SDA pass through SYNC_STAGES FFs (SDA reset value 1). Rise/fall are detected on the synchronized copies.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
- START or repeated START from any state goes to ADDR, clears the bit counter and releases SDA. STOP from any state goes to IDLE, releases SDA and clears busy.
- Bit sampling is on synchronized SCL rise, MSB first. SDA is changed only on synchronized SCL fall.
- FSM states: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: shift 8 bits, then:
  - addr[7:1] == DEV_ADDR: drive SDA=0 on the next SCL fall (ADDR_ACK), pulse addr_hit, set busy.
  - R/W = 0: next state SUB.
  - R/W = 1: pulse reg_rd with reg_addr = pointer, latch reg_rdata, next state RDATA.
  - Mismatch: go to IGNORE and never drive SDA until START or STOP.
- SUB: 8 bits load the pointer. ACK it, then go to WDATA.
- WDATA: 8 bits, then on the 8th SCL rise:
  - reg_wdata = byte, reg_addr = pointer, pulse reg_wr for one cycle.
  - ACK, then return to WDATA (next byte).
- RDATA: drive the latched byte MSB first. After the 8th SCL fall release SDA and go to RDATA_ACK.
- RDATA_ACK: sample the master ACK on SCL rise.
  - ACK (0): pulse reg_rd for the next pointer, latch, continue in RDATA.
  - NACK (1): go to IGNORE and wait for STOP or repeated START.
- ACK hold: SDA is held 0 from the SCL fall after bit 8 until the following SCL fall, then released.
- Data hold: SDA is never changed while synchronized SCL is high, except when released by START/STOP detection.
- Reset mid-transaction releases SDA immediately (asynchronous).
- A write with only the device address (no sub-address byte) issues no reg_wr.
- Pointer wraps 8'hFF -> 8'h00.

Optional Feature:
- I2C_AUTO_INC_EN.
- Defined: the pointer increments after every reg_wr and after every read byte, giving burst access.
- Undefined: the pointer changes only via the SUB byte. Repeated data bytes all address the same register.

Decomposition:
- Shared package i2c_pkg holds:
  - FSM state encoding.
  - Constants I2C_ACK = 1'b0 and I2C_NACK = 1'b1.
  - Byte width 8.
- Sub-module i2c_line_sync: synchronizer plus edge/START/STOP detector, reusable by the existing master.

Test Plan:
- Write 0x4C/W, sub 0x1B, data 0xA5 -> three ACKs, one reg_wr with reg_addr=0x1B, reg_wdata=0xA5, busy high until STOP.
- Address 0x4D/W -> SDA never driven (NACK), no addr_hit, no reg_wr, FSM in IGNORE until STOP.
- Write sub 0x10, repeated START, 0x4C/R, reg_rdata=0x3C -> reg_rd with reg_addr=0x10, bus bits 0x3C, master NACK -> SDA released.
- Burst write sub 0xFE, data 0x11, 0x22, 0x33 with I2C_AUTO_INC_EN:
  - defined -> writes to 0xFE, 0xFF, 0x00.
  - undefined -> all three writes to 0xFE.
- Assert reset during the ACK of the sub-address byte -> SDA goes Z the same cycle, outputs at reset values, next START decoded normally.
- STOP in the middle of a data byte (bit 4) -> no reg_wr, busy=0, FSM in IDLE.
